// File: rtl/uram_wght_bank_if.sv
// Load/read/clear bus for the multi-bank UltraRAM weight store.
// The master drives requests; the slave (the weight bank) returns ready, busy and read data.
interface uram_wght_bank_if #(
  parameter int NUM_BANKS = 4,
  parameter int BIT_WIDTH = 32,
  parameter int ADDR_W    = 14,
  parameter int BANK_W    = 2
);
  logic                           clr_start;
  logic                           busy;
  logic                           wr_valid;
  logic                           wr_ready;
  logic [BANK_W-1:0]              wr_bank;
  logic [ADDR_W-1:0]              wr_addr;
  logic [BIT_WIDTH-1:0]           wr_data;
  logic                           rd_valid;
  logic                           rd_ready;
  logic [ADDR_W-1:0]              rd_addr;
  logic                           rd_data_valid;
  logic [NUM_BANKS*BIT_WIDTH-1:0] rd_data;

  modport master (
    output clr_start, wr_valid, wr_bank, wr_addr, wr_data, rd_valid, rd_addr,
    input  busy, wr_ready, rd_ready, rd_data_valid, rd_data
  );

  modport slave (
    input  clr_start, wr_valid, wr_bank, wr_addr, wr_data, rd_valid, rd_addr,
    output busy, wr_ready, rd_ready, rd_data_valid, rd_data
  );
endinterface

// File: rtl/uram_wght_bank.sv
// NUM_BANKS parallel signed weight RAMs with a broadcast row read, valid/ready load port,
// RD_LAT-cycle pipelined read and a sequencer that zeroes every bank one row per cycle.
module uram_wght_bank #(
  parameter  int NUM_BANKS  = 4,
  parameter  int RAM_DEPTH  = 10485,
  parameter  int BIT_WIDTH  = 32,
  parameter  int RD_LAT     = 2,
  parameter  int INIT_CLEAR = 1,
  localparam int ADDR_W     = $clog2(RAM_DEPTH),
  localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input logic               clk,
  input logic               rst_n,
  uram_wght_bank_if.slave   bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  logic [0:0]                     state;
  logic [ADDR_W-1:0]              clr_cnt;
  logic                           wr_fire;
  logic                           rd_fire;
  logic                           wr_in_range;
  logic                           clr_we;
  logic [RD_LAT-1:0]              vld;
  logic [NUM_BANKS*BIT_WIDTH-1:0] ram_flat;

  assign bus.busy          = (state == ST_CLEAR);
  assign bus.wr_ready      = (state == ST_IDLE);
  assign bus.rd_ready      = (state == ST_IDLE);
  assign wr_fire           = bus.wr_valid & bus.wr_ready;
  assign rd_fire           = bus.rd_valid & bus.rd_ready;
  assign wr_in_range       = ({1'b0, bus.wr_addr} < DEPTH_X);
  // RAM is never written while reset is held, even though the FSM sits in CLEAR.
  assign clr_we            = rst_n & (state == ST_CLEAR);
  assign bus.rd_data_valid = vld[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
      clr_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (bus.clr_start) state <= ST_CLEAR;
    end else begin
      if (clr_cnt == LAST_ADDR) begin
        state   <= ST_IDLE;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [BIT_WIDTH-1:0] mem [RAM_DEPTH];
    logic [BIT_WIDTH-1:0] q;

    // Non-blocking read alongside the write gives read-first behaviour on a collision.
    always_ff @(posedge clk) begin
      if (clr_we)
        mem[clr_cnt] <= '0;
      else if (wr_fire && wr_in_range && bus.wr_bank == BANK_W'(b))
        mem[bus.wr_addr] <= bus.wr_data;
      if (rd_fire)
        q <= mem[bus.rd_addr];
    end

    assign ram_flat[b*BIT_WIDTH +: BIT_WIDTH] = q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld <= '0;
    else        vld <= (vld << 1) | RD_LAT'(rd_fire);
  end

  if (RD_LAT == 1) begin : g_lat1
    // The RAM output register has no reset, so mask it until the first read lands.
    logic seen;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       seen <= 1'b0;
      else if (rd_fire) seen <= 1'b1;
    end
    assign bus.rd_data = seen ? ram_flat : '0;
  end else begin : g_latn
    logic [NUM_BANKS*BIT_WIDTH-1:0] stg [1:RD_LAT-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 1; k < RD_LAT; k++) stg[k] <= '0;
      end else begin
        if (vld[0]) stg[1] <= ram_flat;
        for (int unsigned k = 2; k < RD_LAT; k++)
          if (vld[k-1]) stg[k] <= stg[k-1];
      end
    end
    assign bus.rd_data = stg[RD_LAT-1];
  end

endmodule

// File: tb/tb_uram_wght_bank.sv
// Directed bench for uram_wght_bank: clear sequencing, latency, pipelining, read-first
// collisions, aborted clears and out-of-range bank writes.
module tb_uram_wght_bank;
  localparam int NB    = 4;
  localparam int DEPTH = 16;
  localparam int BW    = 32;
  localparam int LAT   = 2;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uram_wght_bank_if #(.NUM_BANKS(NB), .BIT_WIDTH(BW), .ADDR_W(AW), .BANK_W(2)) bus ();
  uram_wght_bank_if #(.NUM_BANKS(3), .BIT_WIDTH(BW), .ADDR_W(AW), .BANK_W(2)) bus3 ();

  uram_wght_bank #(.NUM_BANKS(NB), .RAM_DEPTH(DEPTH), .BIT_WIDTH(BW), .RD_LAT(LAT),
                   .INIT_CLEAR(1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  uram_wght_bank #(.NUM_BANKS(3), .RAM_DEPTH(DEPTH), .BIT_WIDTH(BW), .RD_LAT(LAT),
                   .INIT_CLEAR(0)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int nvec = 0;
  int nerr = 0;
  logic [BW-1:0] model [NB][DEPTH];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] row(input int a);
    logic [127:0] r = '0;
    for (int b = 0; b < NB; b++) r[b*BW +: BW] = model[b][a];
    return r;
  endfunction

  task automatic model_zero();
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < DEPTH; a++) model[b][a] = '0;
  endtask

  task automatic wr(input int b, input int a, input logic [31:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_bank  = 2'(b);
    bus.wr_addr  = 4'(a);
    bus.wr_data  = d;
    check("wr_ready", bus.wr_ready, 1);
    tick();
    bus.wr_valid = 1'b0;
    model[b][a] = d;
  endtask

  task automatic burst(input string tag);
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH) begin
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 4'(i);
      end else begin
        bus.rd_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i - 1 < DEPTH) begin
        check({tag, " valid"}, bus.rd_data_valid, 1);
        check({tag, " data"}, bus.rd_data, row(i - 1));
      end else begin
        check({tag, " idle"}, bus.rd_data_valid, 0);
      end
    end
  endtask

  task automatic count_busy(output int n, output logic rdy, input int pulse_at);
    n = 0;
    rdy = 1'b0;
    while (bus.busy && n < 100) begin
      if (bus.wr_ready || bus.rd_ready) rdy = 1'b1;
      if (n == pulse_at) bus.clr_start = 1'b1;
      tick();
      bus.clr_start = 1'b0;
      n++;
    end
  endtask

  int   n;
  logic rdy;
  logic [127:0] old_row;

  initial begin
    rst_n = 1'b1;
    {bus.clr_start, bus.wr_valid, bus.rd_valid} = '0;
    bus.wr_bank = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    {bus3.clr_start, bus3.wr_valid, bus3.rd_valid} = '0;
    bus3.wr_bank = '0; bus3.wr_addr = '0; bus3.wr_data = '0; bus3.rd_addr = '0;
    #2 rst_n = 1'b0;
    tick();
    tick();

    check("rst busy", bus.busy, 1);
    check("rst wr_ready", bus.wr_ready, 0);
    check("rst rd_valid", bus.rd_data_valid, 0);
    check("rst rd_data", bus.rd_data, 0);
    check("rst3 busy", bus3.busy, 0);
    check("rst3 wr_ready", bus3.wr_ready, 1);
    check("rst3 rd_valid", bus3.rd_data_valid, 0);

    // Initial clear after reset release
    rst_n = 1'b1;
    count_busy(n, rdy, -1);
    check("init clr len", 128'(n), 16);
    check("init clr ready", rdy, 0);
    model_zero();
    burst("clr rows");

    // Signed write and single-read latency
    wr(2, 5, 32'hFFFF_FFF9);
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 4'd5;
    tick();
    bus.rd_valid = 1'b0;
    check("lat1 valid", bus.rd_data_valid, 0);
    tick();
    check("lat2 valid", bus.rd_data_valid, 1);
    check("lat2 data", bus.rd_data, 128'h0000_0000_FFFF_FFF9_0000_0000_0000_0000);
    tick();
    check("post valid", bus.rd_data_valid, 0);
    check("hold data", bus.rd_data, 128'h0000_0000_FFFF_FFF9_0000_0000_0000_0000);

    // Read-first collision
    wr(0, 3, 32'd9);
    old_row = row(3);
    bus.wr_valid = 1'b1; bus.wr_bank = 2'd0; bus.wr_addr = 4'd3; bus.wr_data = 32'd100;
    bus.rd_valid = 1'b1; bus.rd_addr = 4'd3;
    tick();
    bus.wr_valid = 1'b0;
    model[0][3] = 32'd100;
    tick();
    bus.rd_valid = 1'b0;
    check("coll valid", bus.rd_data_valid, 1);
    check("coll old", bus.rd_data, old_row);
    check("coll old9", bus.rd_data, 128'd9);
    tick();
    check("next valid", bus.rd_data_valid, 1);
    check("next new", bus.rd_data, 128'd100);

    // Back-to-back reads
    wr(1, 12, 32'h1234_5678);
    wr(3, 15, 32'hFFFF_FFFF);
    burst("b2b");
    check("b2b hold", bus.rd_data, row(15));

    // Clear, ignored re-start, then reset mid-clear
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    check("clr busy", bus.busy, 1);
    check("clr rd_ready", bus.rd_ready, 0);
    repeat (5) tick();
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    check("clr2 busy", bus.busy, 1);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("abort busy", bus.busy, 1);
    check("abort rd_data", bus.rd_data, 0);
    check("abort valid", bus.rd_data_valid, 0);
    tick();
    rst_n = 1'b1;
    count_busy(n, rdy, -1);
    check("reclr len", 128'(n), 16);
    check("reclr ready", rdy, 0);
    model_zero();
    burst("reclr rows");

    // clr_start while busy must not extend the clear
    wr(0, 0, 32'd55);
    wr(2, 9, 32'd77);
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    count_busy(n, rdy, 10);
    check("restart len", 128'(n), 16);
    model_zero();
    burst("restart rows");

    // Out-of-range bank write on the 3-bank instance
    for (int b = 0; b < 3; b++) begin
      bus3.wr_valid = 1'b1;
      bus3.wr_bank  = 2'(b);
      bus3.wr_addr  = 4'd7;
      bus3.wr_data  = 32'hA0 + 32'(b);
      tick();
    end
    bus3.wr_bank = 2'd3;
    bus3.wr_data = 32'hDEAD;
    check("oob wr_ready", bus3.wr_ready, 1);
    tick();
    bus3.wr_valid = 1'b0;
    bus3.rd_valid = 1'b1;
    bus3.rd_addr  = 4'd7;
    tick();
    bus3.rd_valid = 1'b0;
    tick();
    check("oob valid", bus3.rd_data_valid, 1);
    check("oob data", 128'(bus3.rd_data), 128'h0000_00A2_0000_00A1_0000_00A0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
